// File: rtl/fpu_issue.sv
// FP issue/return stage: one request in flight, one-hot start pulse to the FPU,
// bounded wait for the result, response to writeback, saturating perf counters.
module fpu_issue #(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_x1,
   input  logic [31:0]      req_x2,
   input  logic [TAG_W-1:0] req_tag,
   output logic [9:0]       fpu_opcode,
   output logic [31:0]      fpu_x1,
   output logic [31:0]      fpu_x2,
   input  logic [31:0]      fpu_y,
   input  logic             fpu_valid,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_y,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_issued,
   output logic [CNT_W-1:0] cnt_timeout
);

   typedef enum logic [1:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_RESP
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [3:0]       op_q;
   logic [31:0]      x1_q, x2_q, y_q;
   logic [TAG_W-1:0] tag_q;
   logic             err_q;
   logic [15:0]      wcnt_q;
   logic [CNT_W-1:0] iss_q, tmo_q;
   logic             illegal, tmo_hit;

   assign illegal = (req_op >= 4'd10);
   assign tmo_hit = (wcnt_q == WAIT_LAST);

   always_ff @(posedge sys_clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (req_valid) state_d = illegal ? S_RESP : S_ISSUE;
         S_ISSUE: state_d = fpu_valid ? S_RESP : S_WAIT;
         S_WAIT:  if (fpu_valid || tmo_hit) state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == S_IDLE);
      rsp_valid  = (state_q == S_RESP);
      busy       = (state_q != S_IDLE);
      fpu_opcode = '0;
      if (state_q == S_ISSUE) fpu_opcode = 10'd1 << op_q;
   end

   // Datapath; fpu_valid outside ISSUE/WAIT is a stale result and is dropped.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         op_q   <= '0;
         x1_q   <= '0;
         x2_q   <= '0;
         y_q    <= '0;
         tag_q  <= '0;
         err_q  <= 1'b0;
         wcnt_q <= '0;
         iss_q  <= '0;
         tmo_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  x1_q  <= req_x1;
                  x2_q  <= req_x2;
                  tag_q <= req_tag;
                  if (illegal) begin
                     y_q   <= '0;
                     err_q <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               wcnt_q <= '0;
               if (iss_q != '1) iss_q <= iss_q + 1'b1;
               if (fpu_valid) begin
                  y_q   <= fpu_y;
                  err_q <= 1'b0;
               end
            end
            S_WAIT: begin
               wcnt_q <= wcnt_q + 16'd1;
               if (fpu_valid) begin
                  y_q   <= fpu_y;
                  err_q <= 1'b0;
               end else if (tmo_hit) begin
                  y_q   <= '0;
                  err_q <= 1'b1;
                  if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign fpu_x1      = x1_q;
   assign fpu_x2      = x2_q;
   assign rsp_y       = y_q;
   assign rsp_tag     = tag_q;
   assign rsp_err     = err_q;
   assign cnt_issued  = iss_q;
   assign cnt_timeout = tmo_q;

endmodule
